rm_counter: RTL

RM_COUNTER -- requirements
Module: rm_counter

---
 rtl/rm_counter_pkg.sv | 21 ++
 rtl/rm_priority_enc.sv | 19 +
 rtl/rm_counter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rm_counter_pkg.sv
// Shared CPU micro-sequencer package: register-list counter states, default
// transfer stride and the control-store condition field codes that test it.
package rm_counter_pkg;

  localparam int RM_MASK_W     = 16;
  localparam int RM_STRIDE_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2
  } rm_state_e;

  // Condition-select field of a control-store word; RM_DONE samples rm_counter.done.
  localparam int                   CS_COND_W       = 3;
  localparam logic [CS_COND_W-1:0] CS_COND_ALWAYS  = 3'd0;
  localparam logic [CS_COND_W-1:0] CS_COND_ZERO    = 3'd1;
  localparam logic [CS_COND_W-1:0] CS_COND_CARRY   = 3'd2;
  localparam logic [CS_COND_W-1:0] CS_COND_RM_DONE = 3'd5;

endpackage

// File: rtl/rm_priority_enc.sv
// Lowest-set-bit encoder over the remaining register list.
module rm_priority_enc
  import rm_counter_pkg::*;
(
  input  logic [RM_MASK_W-1:0] mask,
  output logic [3:0]           idx,
  output logic                 any
);

  // Scan high to low so the lowest set bit is the last write.
  always_comb begin
    idx = '0;
    for (int i = RM_MASK_W - 1; i >= 0; i--)
      if (mask[i]) idx = 4'(i);
  end

  assign any = |mask;

endmodule

// File: rtl/rm_counter.sv
// Block-transfer register-list counter: walks a 16-bit register mask in
// ascending order, producing element addresses and the base writeback value.
module rm_counter
  import rm_counter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int STRIDE = RM_STRIDE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [RM_MASK_W-1:0] mask_in,
  input  logic [ADDR_W-1:0]    base_in,
  input  logic                 u_bit,
  input  logic                 p_bit,
  input  logic                 step,
  output logic                 busy,
  output logic                 valid,
  output logic                 done,
  output logic [3:0]           reg_idx,
  output logic [ADDR_W-1:0]    elem_addr,
  output logic [ADDR_W-1:0]    wb_addr,
  output logic [4:0]           count,
  output logic                 empty_err
);

  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  rm_state_e            state_q, state_d;
  logic [RM_MASK_W-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [ADDR_W-1:0]    elem_addr_q, elem_addr_d;
  logic [ADDR_W-1:0]    wb_addr_q, wb_addr_d;
  logic                 u_q, u_d, p_q, p_d;
  logic [4:0]           count_q, count_d;
  logic                 empty_err_q, empty_err_d;
  logic [4:0]           pop;
  logic [3:0]           enc_idx;
  logic                 enc_any;
  logic                 last;
  logic [ADDR_W-1:0]    span;

  rm_priority_enc u_enc (
    .mask (mask_q),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  always_comb begin
    pop = '0;
    for (int i = 0; i < RM_MASK_W; i++) pop = pop + 5'(mask_in[i]);
  end

  assign last = enc_any && ((mask_q & (mask_q - 1'b1)) == '0);
  assign span = STRIDE_A * ADDR_W'(count_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      base_q      <= '0;
      u_q         <= 1'b0;
      p_q         <= 1'b0;
      count_q     <= '0;
      elem_addr_q <= '0;
      wb_addr_q   <= '0;
      empty_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      base_q      <= base_d;
      u_q         <= u_d;
      p_q         <= p_d;
      count_q     <= count_d;
      elem_addr_q <= elem_addr_d;
      wb_addr_q   <= wb_addr_d;
      empty_err_q <= empty_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (load && mask_in != '0) state_d = ST_SETUP;
      ST_SETUP: state_d = ST_RUN;
      ST_RUN:   if (step && last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mask_d      = mask_q;
    base_d      = base_q;
    u_d         = u_q;
    p_d         = p_q;
    count_d     = count_q;
    elem_addr_d = elem_addr_q;
    wb_addr_d   = wb_addr_q;
    empty_err_d = 1'b0;
    case (state_q)
      ST_IDLE: if (load) begin
        mask_d  = mask_in;
        base_d  = base_in;
        u_d     = u_bit;
        p_d     = p_bit;
        count_d = pop;
        // An empty list never leaves IDLE, so writeback is just the base.
        if (mask_in == '0) begin
          wb_addr_d   = base_in;
          empty_err_d = 1'b1;
        end
      end
      ST_SETUP: begin
        wb_addr_d = u_q ? base_q + span : base_q - span;
        unique case ({u_q, p_q})
          2'b10:   elem_addr_d = base_q;
          2'b11:   elem_addr_d = base_q + STRIDE_A;
          2'b00:   elem_addr_d = base_q - span + STRIDE_A;
          default: elem_addr_d = base_q - span;
        endcase
      end
      ST_RUN: if (step) begin
        mask_d      = mask_q & ~(RM_MASK_W'(1) << enc_idx);
        elem_addr_d = elem_addr_q + STRIDE_A;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    valid     = (state_q == ST_RUN);
    done      = (state_q == ST_IDLE) || ((state_q == ST_RUN) && last);
    reg_idx   = enc_idx;
    elem_addr = elem_addr_q;
    wb_addr   = wb_addr_q;
    count     = count_q;
    empty_err = empty_err_q;
  end

endmodule
